// File: rtl/ret_stack.sv
// Return-address stack for CALL/RET: DEPTH x WIDTH LIFO with sticky overflow/underflow flags.
// Define RET_STACK_WRAP_EN to make a push-when-full overwrite the oldest entry instead of dropping it.
module ret_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     call_en,
    input  logic                     ret_en,
    input  logic [WIDTH-1:0]         ret_pc,
    input  logic                     err_clr,
    output logic [WIDTH-1:0]         lr_addr,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     empty,
    output logic                     full,
    output logic                     ovf,
    output logic                     unf
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    top_idx;
    logic [CW-1:0]    count;

    logic [PW-1:0]    ptr_nxt;
    logic [CW-1:0]    count_nxt;
    logic             wr_en;
    logic [PW-1:0]    wr_idx;
    logic             set_ovf;
    logic             set_unf;

    // ptr addresses the next free slot, so the top entry sits one below it
    assign top_idx = ptr - PW'(1);
    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign depth   = count;
    assign lr_addr = empty ? '0 : mem[top_idx];

    always_comb begin
        ptr_nxt   = ptr;
        count_nxt = count;
        wr_en     = 1'b0;
        wr_idx    = ptr;
        set_ovf   = 1'b0;
        set_unf   = 1'b0;

        if (call_en && ret_en) begin
            if (empty) begin
                wr_en     = 1'b1;
                wr_idx    = ptr;
                ptr_nxt   = ptr + PW'(1);
                count_nxt = count + CW'(1);
            end else begin
                // simultaneous CALL/RET replaces the top entry in place
                wr_en  = 1'b1;
                wr_idx = top_idx;
            end
        end else if (call_en) begin
            if (!full) begin
                wr_en     = 1'b1;
                wr_idx    = ptr;
                ptr_nxt   = ptr + PW'(1);
                count_nxt = count + CW'(1);
            end else begin
                set_ovf = 1'b1;
`ifdef RET_STACK_WRAP_EN
                // when full, ptr also addresses the oldest entry
                wr_en   = 1'b1;
                wr_idx  = ptr;
                ptr_nxt = ptr + PW'(1);
`endif
            end
        end else if (ret_en) begin
            if (!empty) begin
                ptr_nxt   = top_idx;
                count_nxt = count - CW'(1);
            end else begin
                set_unf = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr   <= '0;
            count <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            ptr   <= ptr_nxt;
            count <= count_nxt;
            ovf   <= set_ovf | (ovf & ~err_clr);
            unf   <= set_unf | (unf & ~err_clr);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            mem[wr_idx] <= ret_pc;
        end
    end

endmodule
